smvm_issue_ctrl: RTL
====================

Name: smvm_issue_ctrl

Overview:
- Front-end controller for the SMVM datapath.
- Parses the serial input stream into three phases: matrix header, dense vector, then nonzero (value, column, row-start) triples.
- Writes the vector into the vector buffer.
- Packs nonzeros into K-wide batches and issues them to the multiplier/adder-tree lanes with a valid/ready handshake. A short final batch is padded with zeros and masked.
- Tracks the row count and flags protocol errors.

Parameters:
- K, 4, nonzeros per issued batch (number of multiplier lanes)
- VW, 8, value width (signed, two's complement)
- CW, 7, column index width (max 2^CW = 128 columns)
- RW, 8, row count width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  controller accepts the beat this cycle
- in_data  input  VW  header: row count; vector phase: vector element; nonzero phase: matrix value
- in_col  input  CW  header: column count minus 1; nonzero phase: column index; ignored in vector phase
- in_ipv  input  1  nonzero phase: first nonzero of a new row
- in_last  input  1  final beat of the matrix (last vector beat if there are no nonzeros, else last nonzero)
- vec_we  output  1  vector buffer write strobe
- vec_waddr  output  CW  vector buffer write address
- vec_wdata  output  VW  vector buffer write data
- iss_valid  output  1  batch valid
- iss_ready  input  1  datapath accepts the batch
- iss_val  output  K*VW  lane values; lane 0 in the MSBs
- iss_col  output  K*CW  lane column indices; lane 0 in the MSBs
- iss_ipv  output  K  per-lane row-start flags; bit K-1 is lane 0
- iss_mask  output  K  per-lane occupancy; bit K-1 is lane 0
- iss_last  output  1  batch is the final batch of the matrix
- row_cnt  output  RW  row-start flags seen so far
- done  output  1  one-cycle pulse when the matrix completes
- err  output  1  sticky protocol error

Behaviour:
- Reset: state=IDLE; in_ready=1; iss_valid=0; all iss_* fields=0; vec_we=0; row_cnt=0; done=0; err=0; internal counters=0.
- A beat transfers when in_valid&&in_ready. A batch transfers when iss_valid&&iss_ready.
- States: IDLE, VEC, NNZ, DONE.
- IDLE (in_ready=1): on a transfer, latch rows=in_data and cols=in_col+1, clear err and row_cnt, go to VEC. A header with in_data==0 is ignored and the state stays IDLE.
- VEC (in_ready=1): each transfer drives vec_we/vec_waddr/vec_wdata combinationally; vec_waddr=vector count, starting at 0.
  - After beat cols-1 go to NNZ.
  - If in_last is set on that beat, go to DONE with no issue.
  - in_last on any earlier vector beat sets err and goes to DONE.
- NNZ: each transfer stores {value, col, ipv} in collect slot coll_cnt.
  - Batch close: the K-th beat, or any beat with in_last. The closing beat and the collected slots load the issue register the next cycle, with iss_valid=1.
  - Unfilled lanes: value=0, col=0, ipv=0, mask=0. iss_last=in_last of the closing beat.
  - in_ready=0 only when the current beat would close a batch while iss_valid=1 and iss_ready=0. A batch accepted in the same cycle frees the slot, so full throughput is one beat per cycle.
- Issue register holds its contents stable while iss_valid && !iss_ready.
- After the closing beat that carries in_last: in_ready=0 until that batch transfers. Then done pulses in the same cycle as the transfer (state DONE), and the next cycle is IDLE.
- DONE is one cycle with in_ready=0 and done=1; used for the no-nonzero and error-exit paths.
- row_cnt increments on each accepted nonzero with in_ipv=1 and saturates at 2^RW-1.
- err sets on any of:
  - first nonzero with in_ipv=0;
  - in_col >= cols in the nonzero phase;
  - row_cnt exceeding rows.
- Error handling: beats are still accepted and issued; err is not cleared until the next header.
- Reset mid-operation returns everything to reset values. No partial batch is issued.

Test Plan:
- Header rows=2, in_col=3 (cols=4); vector 1,2,3,4; then 4 nonzeros (5,c0,ipv1),(6,c2,0),(7,c1,ipv1),(8,c3,0,last) with iss_ready=1 -> vec_waddr 0..3 written; one batch val={5,6,7,8}, col={0,2,1,3}, ipv=4'b1010, mask=4'b1111, iss_last=1; done pulses in the transfer cycle; row_cnt=2; err=0.
- Same header, 6 nonzeros, last on the 6th -> two batches: mask 1111 with iss_last=0, then mask 1100 with lanes 2-3 zero and iss_last=1.
- Back-pressure: iss_ready=0 for 5 cycles while 8 nonzeros stream -> in_ready drops on the 8th beat; first batch held stable; after iss_ready=1 both batches transfer in order; no beat lost.
- in_last on the final vector beat (cols=2) -> no iss_valid; done pulses once; next beat is treated as a header.
- Nonzero with in_col=5 when cols=4, plus a first nonzero with ipv=0 -> err=1 and stays 1; a new header clears it.
- Assert rst_n low with 3 nonzeros collected and iss_valid=1 -> all outputs return to reset values; no batch issued after reset.

Source files
------------

// File: rtl/smvm_issue_ctrl.sv
// -----------------------------------------------------------------------------
// smvm_issue_ctrl
//   Front-end controller for the SMVM datapath. It consumes one serial input
//   stream in three phases: a matrix header, the dense vector, and the
//   nonzero (value, column, row-start) triples. Vector elements go straight to
//   the vector buffer. Nonzeros are packed into K-wide batches and issued to
//   the multiplier lanes with a valid/ready handshake. A short final batch is
//   zero-padded and masked.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake
//   in_data               header: row count | vector element | nonzero value
//   in_col                header: columns-1 | (ignored)       | column index
//   in_ipv                nonzero phase: first nonzero of a new row
//   in_last               final beat of the matrix
//   vec_we/waddr/wdata    vector buffer write port (combinational from input)
//   iss_valid/iss_ready   batch handshake
//   iss_val/col/ipv/mask  batch lanes, lane 0 in the MSBs
//   iss_last              batch is the final batch of the matrix
//   row_cnt               row-start flags seen so far (saturating)
//   done                  one-cycle pulse when the matrix completes
//   err                   sticky protocol error, cleared by the next header
// -----------------------------------------------------------------------------
module smvm_issue_ctrl #(
  parameter int K  = 4,   // lanes per batch, K >= 2
  parameter int VW = 8,
  parameter int CW = 7,
  parameter int RW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VW-1:0]   in_data,
  input  logic [CW-1:0]   in_col,
  input  logic            in_ipv,
  input  logic            in_last,
  output logic            vec_we,
  output logic [CW-1:0]   vec_waddr,
  output logic [VW-1:0]   vec_wdata,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [K*VW-1:0] iss_val,
  output logic [K*CW-1:0] iss_col,
  output logic [K-1:0]    iss_ipv,
  output logic [K-1:0]    iss_mask,
  output logic            iss_last,
  output logic [RW-1:0]   row_cnt,
  output logic            done,
  output logic            err
);

  localparam int CNT_W = $clog2(K);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VEC  = 2'd1;
  localparam logic [1:0] S_NNZ  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [RW-1:0]    rows;
  logic [CW-1:0]    cols_m1;     // columns minus one, as carried by the header
  logic [CW-1:0]    vec_cnt;
  logic [CNT_W-1:0] coll_cnt;    // nonzeros parked in the collect slots
  logic             nz_seen;     // at least one nonzero accepted this matrix

  // Collect slots hold the first K-1 nonzeros of a batch; the closing beat
  // bypasses them and goes straight into the issue register.
  logic [VW-1:0]    coll_val [K];
  logic [CW-1:0]    coll_col [K];
  logic [K-1:0]     coll_ipv;

  logic [VW-1:0]    lane_val [K];
  logic [CW-1:0]    lane_col [K];
  logic [K-1:0]     lane_ipv;
  logic [K-1:0]     lane_mask;

  logic             in_fire;
  logic             closes;
  logic             issue_free;
  logic             load;
  logic [RW-1:0]    row_inc;

  assign in_fire    = in_valid && in_ready;
  assign closes     = (state == S_NNZ) && ((coll_cnt == CNT_W'(K-1)) || in_last);
  // The issue register can take a new batch if it is empty or being drained
  // this very cycle, which keeps throughput at one beat per cycle.
  assign issue_free = !iss_valid || iss_ready;
  assign load       = in_fire && closes;
  assign row_inc    = (&row_cnt) ? row_cnt : row_cnt + 1'b1;

  assign vec_we     = (state == S_VEC) && in_valid;
  assign vec_waddr  = vec_cnt;
  assign vec_wdata  = in_data;

  // On the nonzero-completion path done coincides with the last batch
  // transfer; on the vector-only and error paths the issue register is empty.
  assign done       = (state == S_DONE) && issue_free;

  // NOTE: every signal written in a combinational block gets a default
  // assignment first so no path leaves it unassigned and infers a latch.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_VEC:   in_ready = 1'b1;
      S_NNZ:   in_ready = !(closes && !issue_free);
      default: in_ready = 1'b0;
    endcase
  end

  // Assemble the batch the closing beat would issue: parked slots first,
  // then the closing beat itself, then zero padding with mask cleared.
  always_comb begin
    lane_ipv  = '0;
    lane_mask = '0;
    for (int i = 0; i < K; i++) begin
      lane_val[i] = '0;
      lane_col[i] = '0;
      if (CNT_W'(i) < coll_cnt) begin
        lane_val[i]  = coll_val[i];
        lane_col[i]  = coll_col[i];
        lane_ipv[i]  = coll_ipv[i];
        lane_mask[i] = 1'b1;
      end else if (CNT_W'(i) == coll_cnt) begin
        lane_val[i]  = in_data;
        lane_col[i]  = in_col;
        lane_ipv[i]  = in_ipv;
        lane_mask[i] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rows     <= '0;
      cols_m1  <= '0;
      vec_cnt  <= '0;
      coll_cnt <= '0;
      nz_seen  <= 1'b0;
      row_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A zero-row header describes nothing; drop it and stay here.
          if (in_fire && (in_data != '0)) begin
            rows     <= RW'(in_data);
            cols_m1  <= in_col;
            vec_cnt  <= '0;
            coll_cnt <= '0;
            nz_seen  <= 1'b0;
            row_cnt  <= '0;
            err      <= 1'b0;
            state    <= S_VEC;
          end
        end
        S_VEC: begin
          if (in_fire) begin
            vec_cnt <= vec_cnt + 1'b1;
            if (vec_cnt == cols_m1) begin
              state <= in_last ? S_DONE : S_NNZ;
            end else if (in_last) begin
              err   <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_NNZ: begin
          if (in_fire) begin
            nz_seen <= 1'b1;
            if (in_ipv) row_cnt <= row_inc;
            if ((!nz_seen && !in_ipv) || (in_col > cols_m1) ||
                (in_ipv && (row_inc > rows))) begin
              err <= 1'b1;
            end
            if (closes) begin
              coll_cnt <= '0;
              if (in_last) state <= S_DONE;
            end else begin
              coll_cnt <= coll_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (issue_free) state <= S_IDLE;
        end
      endcase
    end
  end

  // NOTE: the collect slots are storage, not control; they carry no reset
  // because coll_cnt alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (in_fire && (state == S_NNZ) && !closes) begin
      coll_val[coll_cnt] <= in_data;
      coll_col[coll_cnt] <= in_col;
      coll_ipv[coll_cnt] <= in_ipv;
    end
  end

  // Issue register: loads on a closing beat, otherwise holds until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_val   <= '0;
      iss_col   <= '0;
      iss_ipv   <= '0;
      iss_mask  <= '0;
      iss_last  <= 1'b0;
    end else if (load) begin
      iss_valid <= 1'b1;
      iss_last  <= in_last;
      for (int i = 0; i < K; i++) begin
        iss_val[(K-1-i)*VW +: VW] <= lane_val[i];
        iss_col[(K-1-i)*CW +: CW] <= lane_col[i];
        iss_ipv[K-1-i]            <= lane_ipv[i];
        iss_mask[K-1-i]           <= lane_mask[i];
      end
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

endmodule
